dev_bridge: RTL

CPU-side initiator for the memory-mapped device bus used by the timer and sibling peripherals. Accepts one CPU load/store at a time and decodes its address to a device window. Drives the device word offset, write strobe and write data, then returns registered read data with a one-cycle acknowledge. Also collects device interrupt lines into a maskable pending register and presents them to CP0 as hardware interrupts.

---
 rtl/bridge_pkg.sv | 34 +++
 rtl/irq_pending.sv | 48 ++++
 rtl/dev_bridge.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bridge_pkg
// Brief    : Shared types and constants for the CPU-to-device bus bridge
// Revision : 1.0 - initial release
// ============================================================================
package bridge_pkg;

   // Bridge FSM encoding
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   // Every device window and the bridge's own register window span 32 bytes
   localparam logic [31:0] c_win_size = 32'h20;

   // Word offsets of the bridge's own registers
   localparam logic [2:0] c_off_mask = 3'd0;
   localparam logic [2:0] c_off_pend = 3'd1;

   // Upper bound on the number of device windows
   localparam int NDEV_MAX = 4;

   // True when addr falls within [base, base + span)
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
      return (addr >= base) && ((addr - base) < span);
   endfunction

endpackage
`default_nettype wire

// File: rtl/irq_pending.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending
// Brief    : Rising-edge interrupt capture with W1C pending bits and a mask
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending
   import bridge_pkg::*;
#(
   parameter int NDEV = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NDEV-1:0] irq,
   input  logic            mask_we,
   input  logic            pend_w1c,
   input  logic [NDEV-1:0] wdata,
   output logic [NDEV-1:0] mask,
   output logic [NDEV-1:0] pend
);

   logic [NDEV-1:0] r_irq_prev;
   logic [NDEV-1:0] w_rise;
   logic [NDEV-1:0] w_clr;

   // Rising-edge detect and the clear vector for this cycle
   always_comb begin
      w_rise = irq & ~r_irq_prev;
      w_clr  = pend_w1c ? wdata : '0;
   end

   // Pending bits: clear first, then OR in new edges so a same-cycle set wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_prev <= '0;
         pend       <= '0;
         mask       <= '0;
      end else begin
         r_irq_prev <= irq;
         pend       <= (pend & ~w_clr) | w_rise;
         if (mask_we) begin
            mask <= wdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dev_bridge.sv
`default_nettype none
// ============================================================================
// Module   : dev_bridge
// Brief    : CPU load/store initiator for the memory-mapped device bus with
//            maskable interrupt collection towards CP0
// Revision : 1.0 - initial release
// ============================================================================
module dev_bridge
   import bridge_pkg::*;
#(
   parameter int          NDEV     = 2,
   parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
   parameter logic [31:0] BRG_BASE = 32'h0000_7F80
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [31:0]          cpu_addr,
   input  logic [31:0]          cpu_wdata,
   output logic [31:0]          cpu_rdata,
   output logic                 cpu_ack,
   output logic                 cpu_err,
   output logic [2:0]           dev_addr,
   output logic [31:0]          dev_wdata,
   output logic [NDEV-1:0]      dev_we,
   input  logic [32*NDEV-1:0]   dev_rdata,
   input  logic [NDEV-1:0]      dev_irq,
   output logic [5:0]           hwint
);

   state_t          r_state;
   logic [NDEV-1:0] r_sel;
   logic            r_brg;
   logic            r_we;

   logic [NDEV-1:0] w_sel;
   logic            w_dev_hit;
   logic            w_brg_hit;
   logic            w_aligned;
   logic [31:0]     w_dev_rd;
   logic [31:0]     w_brg_rd;
   logic [NDEV-1:0] w_mask;
   logic [NDEV-1:0] w_pend;
   logic            w_mask_we;
   logic            w_pend_w1c;

   // Decode the live CPU address into a one-hot device select or bridge hit
   always_comb begin
      for (int i = 0; i < NDEV; i++) begin
         w_sel[i] = in_window(cpu_addr, DEV_BASE + 32'(i) * c_win_size, c_win_size);
      end
      w_dev_hit = |w_sel;
      w_brg_hit = in_window(cpu_addr, BRG_BASE, c_win_size);
      w_aligned = (cpu_addr[1:0] == 2'b00);
   end

   // Read-data selection for the latched target during ACCESS
   always_comb begin
      w_dev_rd = '0;
      for (int i = 0; i < NDEV; i++) begin
         if (r_sel[i]) begin
            w_dev_rd = dev_rdata[32*i +: 32];
         end
      end
      case (dev_addr)
         c_off_mask: w_brg_rd = 32'(w_mask);
         c_off_pend: w_brg_rd = 32'(w_pend);
         default:    w_brg_rd = '0;
      endcase
   end

   // Bridge register write strobes, only ever active during ACCESS
   always_comb begin
      w_mask_we  = (r_state == ACCESS) && r_brg && r_we && (dev_addr == c_off_mask);
      w_pend_w1c = (r_state == ACCESS) && r_brg && r_we && (dev_addr == c_off_pend);
   end

   // Access FSM: latch request, drive the device bus for one cycle, ack once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_sel     <= '0;
         r_brg     <= 1'b0;
         r_we      <= 1'b0;
         cpu_ack   <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         dev_we    <= '0;
         dev_addr  <= '0;
         dev_wdata <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               cpu_ack <= 1'b0;
               cpu_err <= 1'b0;
               if (cpu_req) begin
                  r_we      <= cpu_we;
                  r_sel     <= w_sel;
                  r_brg     <= w_brg_hit;
                  dev_addr  <= cpu_addr[4:2];
                  dev_wdata <= cpu_wdata;
                  if ((w_dev_hit || w_brg_hit) && w_aligned) begin
                     r_state <= ACCESS;
                     dev_we  <= cpu_we ? w_sel : '0;
                  end else begin
                     r_state   <= RESP;
                     cpu_ack   <= 1'b1;
                     cpu_err   <= 1'b1;
                     cpu_rdata <= '0;
                  end
               end
            end
            ACCESS: begin
               dev_we  <= '0;
               cpu_ack <= 1'b1;
               cpu_err <= 1'b0;
               if (r_we) begin
                  cpu_rdata <= '0;
               end else if (r_brg) begin
                  cpu_rdata <= w_brg_rd;
               end else begin
                  cpu_rdata <= w_dev_rd;
               end
               r_state <= RESP;
            end
            RESP: begin
               cpu_ack <= 1'b0;
               cpu_err <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               dev_we  <= '0;
               cpu_ack <= 1'b0;
               cpu_err <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   irq_pending #(
      .NDEV (NDEV)
   ) u_irq_pending (
      .clk      (clk),
      .rst      (rst),
      .irq      (dev_irq),
      .mask_we  (w_mask_we),
      .pend_w1c (w_pend_w1c),
      .wdata    (dev_wdata[NDEV-1:0]),
      .mask     (w_mask),
      .pend     (w_pend)
   );

   // Masked pending interrupts go straight to CP0 with no extra latency
   assign hwint = {{(6-NDEV){1'b0}}, w_mask & w_pend};

endmodule
`default_nettype wire
